serial_adder: RTL and testbench

Bit-serial adder that adds two WIDTH-bit operands plus a carry-in over WIDTH cycles, one bit per cycle, LSB first. It contains a single `full_adder` instance as its only adder cell and registers the carry between bit slices. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake. The block is the area-minimal alternative to a WIDTH-bit ripple adder in the arithmetic library.

---
 rtl/serial_adder.sv | 147 ++++++++++++++
 tb/tb_serial_adder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: computes A + B + c_In over WIDTH clock cycles, one bit
//   per cycle, LSB first, using a single full_adder cell and a registered
//   carry between bit slices.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   A, B, c_In are valid
//   in_ready   out  block can accept operands (IDLE)
//   A, B       in   WIDTH-bit operands, sampled only at the accept edge
//   c_In       in   carry into bit 0, sampled only at the accept edge
//   out_valid  out  sum / c_Out hold a completed result (DONE)
//   out_ready  in   downstream accepts the result
//   sum        out  A+B+c_In modulo 2^WIDTH (dedicated output register)
//   c_Out      out  carry out of bit WIDTH-1 (dedicated output register)

// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_In,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_Out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_sh_q, s_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   s_shift;

  // The only adder cell in the block.
  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB while earlier bits move toward the LSB.
  // Written as shift/or so it also holds for WIDTH=1 (s_sh >> 1 is then 0).
  assign s_shift = (s_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = c_In;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_sh_d  = s_shift;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Final slice: capture the complete result including this bit.
          sum_d   = s_shift;
          c_out_d = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        // in_valid is deliberately ignored here; no accept on retirement.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_Out     = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Main WIDTH=8 instance
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          c_In = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  sum;
  logic          c_Out;

  // WIDTH=1 instance
  logic iv1 = 1'b0;
  logic or1 = 1'b1;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic c1 = 1'b0;
  logic ir1;
  logic ov1;
  logic s1;
  logic co1;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .c_In      (c_In),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_Out     (c_Out)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .A         (a1),
    .B         (b1),
    .c_In      (c1),
    .out_valid (ov1),
    .out_ready (or1),
    .sum       (s1),
    .c_Out     (co1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  bit          chk_en = 1'b0;
  int          cyc = 0;
  bit          mbusy = 1'b0;     // an operation is between accept and retirement
  int          acc_cyc = 0;
  int          acc_count = 0;
  bit          exp_ov;
  logic [8:0]  exp_q[$];         // expected {c_Out,sum} in issue order
  logic [8:0]  last_res = '0;    // value output registers must hold when idle

  // Handshake timing model: accept when idle, result visible WIDTH+1 cycles
  // after the accept cycle, retire on out_ready, reset discards everything.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_ov = mbusy && (cyc >= acc_cyc + W + 1);
        chk("in_ready", 32'(in_ready), 32'(!mbusy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (rst) begin
          mbusy = 1'b0;
        end else if (exp_ov && out_ready) begin
          mbusy = 1'b0;
        end else if (!mbusy && in_valid) begin
          mbusy = 1'b1;
          acc_cyc = cyc;
          acc_count++;
        end
      end
      cyc++;
    end
  end

  // Result monitor: whenever the DUT presents a result, compare with the
  // oldest expectation; pop it when the DUT retires it.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got 0x%0h expected none at %0t", {c_Out, sum}, $time);
          end else begin
            chk("result", 32'({c_Out, sum}), 32'(exp_q[0]));
          end
        end else begin
          chk("held_result", 32'({c_Out, sum}), 32'(last_res));
        end
        if (rst) begin
          exp_q.delete();
          last_res = '0;
        end else if (out_valid === 1'b1 && out_ready && exp_q.size() > 0) begin
          last_res = exp_q.pop_front();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_rdy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one operation and hold it until the model sees it accepted.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    int start;
    int n;
    start = acc_count;
    n = 0;
    A = a;
    B = b;
    c_In = c;
    in_valid = 1'b1;
    while (acc_count == start && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (acc_count == start) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept expected accept at %0t", $time);
    end else begin
      exp_q.push_back(9'(a) + 9'(b) + 9'(c));
    end
    in_valid = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    c_In = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (mbusy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mbusy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy expected idle at %0t", $time);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
  } vec_t;

  vec_t dir_vecs[4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [1:0] e1;
    dir_vecs[0] = '{8'h3C, 8'h0F, 1'b0};
    dir_vecs[1] = '{8'hFF, 8'h01, 1'b0};
    dir_vecs[2] = '{8'hFF, 8'hFF, 1'b1};
    dir_vecs[3] = '{8'h00, 8'h00, 1'b1};

    // Reset; in_valid high during reset must not be accepted.
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed basic add and carry-chain cases.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].c);
      wait_idle();
    end

    // Backpressure: hold result in DONE while in_valid and operands toggle.
    out_ready = 1'b0;
    issue(8'h5A, 8'h33, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      A = 8'($urandom);
      B = 8'($urandom);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    @(posedge clk);
    #1;

    // Reset in the 4th RUN cycle, then a fresh operation.
    issue(8'hAA, 8'h55, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(8'h01, 8'h02, 1'b0);
    wait_idle();

    // Random back-to-back traffic with random gaps and backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        A = 8'($urandom);
        B = 8'($urandom);
        c_In = 1'($urandom);
      end
      issue(8'($urandom), 8'($urandom), 1'($urandom));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // WIDTH=1 build: full-adder truth table, out_valid 2 cycles after accept.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      a1 = i[2];
      b1 = i[1];
      c1 = i[0];
      e1 = 2'(a1) + 2'(b1) + 2'(c1);
      iv1 = 1'b1;
      @(negedge clk);
      chk("w1_in_ready_idle", 32'(ir1), 32'd1);
      chk("w1_out_valid_idle", 32'(ov1), 32'd0);
      @(posedge clk);
      #1;
      iv1 = 1'b0;
      a1 = ~a1;
      b1 = ~b1;
      @(negedge clk);
      chk("w1_in_ready_run", 32'(ir1), 32'd0);
      chk("w1_out_valid_run", 32'(ov1), 32'd0);
      @(negedge clk);
      chk("w1_out_valid_done", 32'(ov1), 32'd1);
      chk("w1_result", 32'({co1, s1}), 32'(e1));
      @(negedge clk);
      chk("w1_in_ready_after", 32'(ir1), 32'd1);
      chk("w1_held", 32'({co1, s1}), 32'(e1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
